// File: rtl/queue_ctrl_2x81.sv
// Ready/valid circular-queue controller for an external 2x81 dual-port RAM (async read, sync write).
// Optional same-cycle empty-queue bypass is enabled by defining QUEUE_FLOW_EN.
module queue_ctrl_2x81 #(
   parameter int WIDTH  = 81,
   parameter int DEPTH  = 2,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              io_flush,
   input  logic              io_enq_valid,
   output logic              io_enq_ready,
   input  logic [WIDTH-1:0]  io_enq_bits,
   output logic              io_deq_valid,
   input  logic              io_deq_ready,
   output logic [WIDTH-1:0]  io_deq_bits,
   output logic [CNT_W-1:0]  io_count,
   output logic [ADDR_W-1:0] ram_W0_addr,
   output logic              ram_W0_en,
   output logic [WIDTH-1:0]  ram_W0_data,
   output logic [ADDR_W-1:0] ram_R0_addr,
   output logic              ram_R0_en,
   input  logic [WIDTH-1:0]  ram_R0_data
);

   logic [ADDR_W-1:0] enq_ptr_q, enq_ptr_d;
   logic [ADDR_W-1:0] deq_ptr_q, deq_ptr_d;
   logic              maybe_full_q, maybe_full_d;
   logic [ADDR_W-1:0] ptr_diff;
   logic              ptr_match, empty, full;
   logic              flow, bypass;
   logic              enq_fire, deq_fire, do_enq, do_deq;

   assign ptr_match = (enq_ptr_q == deq_ptr_q);
   assign empty     = ptr_match & ~maybe_full_q;
   assign full      = ptr_match & maybe_full_q;

`ifdef QUEUE_FLOW_EN
   assign flow = empty & io_enq_valid & ~io_flush & ~reset;
`else
   assign flow = 1'b0;
`endif

   assign io_enq_ready = ~full & ~io_flush & ~reset;
   assign io_deq_valid = (~empty | flow) & ~reset;
   assign io_deq_bits  = flow ? io_enq_bits : ram_R0_data;

   assign enq_fire = io_enq_valid & io_enq_ready;
   assign deq_fire = io_deq_valid & io_deq_ready;
   // A bypassed item is both enqueued and dequeued at the handshake level but never touches RAM or pointers.
   assign bypass   = flow & io_deq_ready;
   assign do_enq   = enq_fire & ~bypass;
   assign do_deq   = deq_fire & ~bypass;

   assign ram_W0_addr = enq_ptr_q;
   assign ram_W0_en   = do_enq;
   assign ram_W0_data = io_enq_bits;
   assign ram_R0_addr = deq_ptr_q;
   assign ram_R0_en   = 1'b1;

   assign ptr_diff = enq_ptr_q - deq_ptr_q;
   assign io_count = full ? CNT_W'(DEPTH) : CNT_W'(ptr_diff);

   always_comb begin
      enq_ptr_d    = enq_ptr_q;
      deq_ptr_d    = deq_ptr_q;
      maybe_full_d = maybe_full_q;
      if (io_flush) begin
         enq_ptr_d    = '0;
         deq_ptr_d    = '0;
         maybe_full_d = 1'b0;
      end else begin
         if (do_enq) enq_ptr_d = enq_ptr_q + ADDR_W'(1);
         if (do_deq) deq_ptr_d = deq_ptr_q + ADDR_W'(1);
         if (do_enq != do_deq) maybe_full_d = do_enq;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         enq_ptr_q    <= '0;
         deq_ptr_q    <= '0;
         maybe_full_q <= 1'b0;
      end else begin
         enq_ptr_q    <= enq_ptr_d;
         deq_ptr_q    <= deq_ptr_d;
         maybe_full_q <= maybe_full_d;
      end
   end

endmodule

// File: tb/tb_queue_ctrl_2x81.sv
// Bench for queue_ctrl_2x81: models the RAM macro and compares the DUT against a queue-based
// reference every cycle; directed scenarios followed by randomized traffic.
module tb_queue_ctrl_2x81;

   localparam int WIDTH  = 81;
   localparam int DEPTH  = 2;
   localparam int ADDR_W = 1;
   localparam int CNT_W  = 2;

   logic              clock;
   logic              reset;
   logic              io_flush;
   logic              io_enq_valid;
   logic              io_enq_ready;
   logic [WIDTH-1:0]  io_enq_bits;
   logic              io_deq_valid;
   logic              io_deq_ready;
   logic [WIDTH-1:0]  io_deq_bits;
   logic [CNT_W-1:0]  io_count;
   logic [ADDR_W-1:0] ram_W0_addr;
   logic              ram_W0_en;
   logic [WIDTH-1:0]  ram_W0_data;
   logic [ADDR_W-1:0] ram_R0_addr;
   logic              ram_R0_en;
   logic [WIDTH-1:0]  ram_R0_data;

   int unsigned n_pass;
   int unsigned n_total;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] model_q [$];

   queue_ctrl_2x81 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clock        (clock),
      .reset        (reset),
      .io_flush     (io_flush),
      .io_enq_valid (io_enq_valid),
      .io_enq_ready (io_enq_ready),
      .io_enq_bits  (io_enq_bits),
      .io_deq_valid (io_deq_valid),
      .io_deq_ready (io_deq_ready),
      .io_deq_bits  (io_deq_bits),
      .io_count     (io_count),
      .ram_W0_addr  (ram_W0_addr),
      .ram_W0_en    (ram_W0_en),
      .ram_W0_data  (ram_W0_data),
      .ram_R0_addr  (ram_R0_addr),
      .ram_R0_en    (ram_R0_en),
      .ram_R0_data  (ram_R0_data)
   );

   // RAM macro: synchronous write, asynchronous read
   assign ram_R0_data = mem[ram_R0_addr];
   always @(posedge clock) if (ram_W0_en) mem[ram_W0_addr] <= ram_W0_data;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      else n_pass++;
   endtask

   function automatic logic [WIDTH-1:0] rnd_bits();
      logic [95:0] r;
      r = {$urandom, $urandom, $urandom};
      return r[WIDTH-1:0];
   endfunction

   // Drive one cycle, compare against the reference queue, then advance both.
   task automatic step(input logic rst, input logic fl, input logic ev,
                       input logic [WIDTH-1:0] bits, input logic dr);
      logic flow, exp_ready, exp_valid, enq_f, deq_f, byp;
      logic [WIDTH-1:0] exp_bits;
      reset = rst; io_flush = fl; io_enq_valid = ev; io_enq_bits = bits; io_deq_ready = dr;
      #2;
      flow = 1'b0;
`ifdef QUEUE_FLOW_EN
      flow = !rst && !fl && ev && model_q.size() == 0;
`endif
      exp_ready = !rst && !fl && model_q.size() < DEPTH;
      exp_valid = !rst && (model_q.size() > 0 || flow);
      exp_bits  = flow ? bits : (model_q.size() > 0 ? model_q[0] : '0);
      enq_f = ev && exp_ready;
      deq_f = dr && exp_valid;
      byp   = flow && dr;
      check("enq_ready", 128'(io_enq_ready), 128'(exp_ready));
      check("deq_valid", 128'(io_deq_valid), 128'(exp_valid));
      check("count",     128'(io_count),     128'(model_q.size()));
      check("w0_en",     128'(ram_W0_en),    128'(enq_f && !byp));
      check("r0_en",     128'(ram_R0_en),    128'(1));
      if (exp_valid) check("deq_bits", 128'(io_deq_bits), 128'(exp_bits));
      if (ram_W0_en) check("w0_data", 128'(ram_W0_data), 128'(bits));
      @(posedge clock);
      #2;
      if (rst || fl) model_q.delete();
      else if (!byp) begin
         if (deq_f) void'(model_q.pop_front());
         if (enq_f) model_q.push_back(bits);
      end
   endtask

   initial begin
      n_pass = 0; n_total = 0;
      reset = 1'b1; io_flush = 1'b0; io_enq_valid = 1'b0; io_enq_bits = '0; io_deq_ready = 1'b0;
      repeat (2) @(posedge clock);
      #2;
      step(1, 0, 0, '0, 0);

      // reset release, back-to-back fill, ordered drain
      step(0, 0, 0, '0, 0);
      step(0, 0, 1, 81'h1_2345, 0);
      step(0, 0, 1, 81'h0_ABCD, 0);
      step(0, 0, 1, 81'h5555, 0);
      step(0, 0, 0, '0, 1);
      step(0, 0, 0, '0, 1);
      step(0, 0, 0, '0, 1);

      // streaming through pointer wrap
      for (int i = 1; i <= 10; i++) step(0, 0, 1, WIDTH'(i), 1);
      step(0, 0, 0, '0, 1);
      step(0, 0, 0, '0, 1);

      // full queue: simultaneous enq/deq only dequeues
      step(0, 0, 1, 81'hA1, 0);
      step(0, 0, 1, 81'hA2, 0);
      step(0, 0, 1, 81'hA3, 1);
      step(0, 0, 1, 81'hA4, 0);
      step(0, 0, 0, '0, 0);

      // flush with enq pending, then reset with one entry
      step(0, 1, 1, 81'hBAD, 1);
      step(0, 0, 0, '0, 0);
      step(0, 0, 1, 81'hC3, 0);
      step(1, 0, 1, 81'hC4, 1);
      step(0, 0, 0, '0, 0);

      // empty queue with enq and deq ready together
      step(0, 0, 1, 81'h7, 1);
      step(0, 0, 0, '0, 1);

      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(63) == 0), ($urandom_range(15) == 0),
              ($urandom_range(3) != 0), rnd_bits(), ($urandom_range(1) == 1));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
